// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-port SPI read arbiter.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_DRAIN
  } state_t;

  localparam logic PORT_IFETCH = 1'b0;
  localparam logic PORT_DLOAD  = 1'b1;

  localparam logic [7:0] ERR_FILL = 8'hFF;

endpackage

// File: rtl/spi_read_arbiter.sv
// Round-robin arbiter/sequencer sharing one spi_read_byte master between
// instruction fetch (port 0) and data load (port 1), with a done watchdog.
module spi_read_arbiter
  import spi_arb_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [1:0]        req_valid,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  output logic [1:0]        req_ready,
  output logic [1:0]        resp_valid,
  output logic [7:0]        resp_data,
  output logic              resp_err,
  output logic              spi_start,
  output logic [ADDR_W-1:0] spi_addr,
  input  logic              spi_busy,
  input  logic              spi_done,
  input  logic [7:0]        spi_data
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nxt;
  logic             owner;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic             grant_ok;
  logic             win;
  logic             timed_out;

  // Counter is 0 in the first WAIT cycle, so hitting CNT_LAST means the
  // count reaches TIMEOUT_CYCLES on this edge.
  assign timed_out = (cnt == CNT_LAST);

  always_comb begin
    win       = (req_valid == 2'b11) ? ~last_grant : req_valid[PORT_DLOAD];
    grant_ok  = (state == ST_IDLE) && ena && (|req_valid) && !spi_busy;
    req_ready = '0;
    if (grant_ok) req_ready[win] = 1'b1;
    resp_valid = '0;
    if (state == ST_RESP) resp_valid[owner] = 1'b1;
    spi_start = (state == ST_ISSUE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (grant_ok) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (spi_done || timed_out) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = resp_err ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (!spi_busy) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= PORT_IFETCH;
      last_grant <= PORT_DLOAD;
      spi_addr   <= '0;
      cnt        <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_ok) begin
        owner      <= win;
        last_grant <= win;
        spi_addr   <= win ? req_addr1 : req_addr0;
      end
      if (state == ST_ISSUE) begin
        cnt <= '0;
      end else if (state == ST_WAIT && cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (state == ST_WAIT) begin
        if (spi_done) begin
          resp_data <= spi_data;
          resp_err  <= 1'b0;
        end else if (timed_out) begin
          resp_data <= ERR_FILL;
          resp_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_read_arbiter.sv
// Randomized bench for spi_read_arbiter against a timestamp-based transaction model.
module tb_spi_read_arbiter;

  localparam int AW  = 16;
  localparam int TMO = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic [1:0]    req_valid;
  logic [AW-1:0] req_addr0, req_addr1;
  logic [1:0]    req_ready, resp_valid;
  logic [7:0]    resp_data;
  logic          resp_err;
  logic          spi_start;
  logic [AW-1:0] spi_addr;
  logic          spi_busy, spi_done;
  logic [7:0]    spi_data;

  always #5 clk = ~clk;

  spi_read_arbiter #(.ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .req_valid(req_valid), .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_err(resp_err),
    .spi_start(spi_start), .spi_addr(spi_addr),
    .spi_busy(spi_busy), .spi_done(spi_done), .spi_data(spi_data)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // stimulus staging, applied just after each rising edge
  logic          rst_i = 1'b0, ena_i = 1'b1, ext_busy = 1'b0;
  logic [1:0]    rv_i = 2'b00, acc;
  logic [AW-1:0] a0_i = '0, a1_i = '0;

  // transaction model: mode 0 free, 1 transaction in flight, 2 draining
  int            mode = 0, start_cyc = 0, resp_cyc = 0;
  logic          m_owner = 1'b0, m_last = 1'b1, m_err = 1'b0, pend_err = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [7:0]    m_data = '0, pend_data = '0;

  // SPI master model
  bit            slv_on = 0;
  int            slv_start = 0, slv_lat = 0;
  logic [7:0]    slv_data = '0;
  int            next_lat = -1;
  bit            use_next = 0;
  logic [7:0]    next_data = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    logic [1:0] exp_ready, exp_rv;
    logic       g;
    bit         accept;
    int         lat;
    logic [7:0] d;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = rst_i; ena = ena_i; req_valid = rv_i;
    req_addr0 = a0_i; req_addr1 = a1_i;
    if (!rst_i) begin
      mode = 0; m_last = 1'b1; m_addr = '0; m_data = '0; m_err = 1'b0; slv_on = 0;
    end
    spi_done = 1'b0;
    spi_data = 8'($urandom);
    spi_busy = ext_busy;
    if (slv_on) begin
      if (cyc > slv_start && cyc < slv_start + slv_lat) spi_busy = 1'b1;
      if (cyc == slv_start + slv_lat) begin
        spi_done = 1'b1; spi_data = slv_data; slv_on = 0;
      end
    end
    if (mode == 1 && cyc == resp_cyc) begin
      m_data = pend_data; m_err = pend_err;
    end
    exp_ready = 2'b00; accept = 0; g = 1'b0;
    if (rst_i && mode == 0 && ena_i && rv_i != 2'b00 && !spi_busy) begin
      g = (rv_i == 2'b11) ? ~m_last : rv_i[1];
      exp_ready[g] = 1'b1;
      accept = 1;
    end
    exp_rv = (mode == 1 && cyc == resp_cyc) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    #4;
    check_val("req_ready",  32'(req_ready),  32'(exp_ready));
    check_val("spi_start",  32'(spi_start),  32'(mode == 1 && cyc == start_cyc));
    check_val("spi_addr",   32'(spi_addr),   32'(m_addr));
    check_val("resp_valid", 32'(resp_valid), 32'(exp_rv));
    check_val("resp_data",  32'(resp_data),  32'(m_data));
    check_val("resp_err",   32'(resp_err),   32'(m_err));
    acc = exp_ready;
    if (accept) begin
      mode = 1; m_owner = g; m_last = g;
      m_addr = g ? a1_i : a0_i;
      start_cyc = cyc + 1;
      lat = (next_lat > 0) ? next_lat : int'($urandom_range(1, TMO + 6));
      d   = use_next ? next_data : 8'($urandom);
      next_lat = -1; use_next = 0;
      slv_on = 1; slv_start = start_cyc; slv_lat = lat; slv_data = d;
      if (lat <= TMO) begin
        resp_cyc = start_cyc + lat + 1; pend_err = 1'b0; pend_data = d;
      end else begin
        resp_cyc = start_cyc + TMO + 1; pend_err = 1'b1; pend_data = 8'hFF;
      end
    end else if (mode == 1 && cyc == resp_cyc) begin
      mode = m_err ? 2 : 0;
    end else if (mode == 2 && !spi_busy) begin
      mode = 0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      rv_i = rv_i & ~acc;
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; req_valid = '0; req_addr0 = '0; req_addr1 = '0;
    spi_busy = 1'b0; spi_done = 1'b0; spi_data = '0;

    run(3);
    rst_i = 1'b1;
    run(2);

    // single read, 20-cycle latency
    a0_i = 16'h0042; rv_i = 2'b01;
    next_lat = 20; next_data = 8'hA5; use_next = 1;
    run(30);

    // tie after reset state: alternation while both stay valid
    a0_i = 16'h0010; a1_i = 16'h0020;
    for (int i = 0; i < 30; i++) begin
      if (next_lat < 0) next_lat = 3;
      rv_i = 2'b11;
      step();
    end
    rv_i = 2'b00; next_lat = -1;
    run(10);

    // externally held busy blocks the grant
    ext_busy = 1'b1; a1_i = 16'h1234; rv_i = 2'b10;
    run(10);
    ext_busy = 1'b0; next_lat = 5;
    run(15);

    // timeout with late done, then done exactly at / just after the limit
    a0_i = 16'h0BAD; rv_i = 2'b01; next_lat = 30;
    run(45);
    rv_i = 2'b10; next_lat = TMO;
    run(32);
    rv_i = 2'b01; next_lat = TMO + 1;
    run(35);

    // ena low blocks grants; ena dropped mid-transaction still completes
    ena_i = 1'b0; rv_i = 2'b11;
    run(8);
    ena_i = 1'b1; next_lat = 6;
    for (int i = 0; i < 20; i++) begin
      step();
      if (acc != 2'b00) ena_i = 1'b0;
      rv_i = rv_i & ~acc;
    end
    ena_i = 1'b1; rv_i = 2'b00;
    run(5);

    // reset while waiting for done
    rv_i = 2'b01; a0_i = 16'h7777; next_lat = 20;
    run(4);
    run(5);
    rst_i = 1'b0; rv_i = 2'b00;
    run(2);
    rst_i = 1'b1;
    run(25);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!rv_i[p]) begin
          if ($urandom_range(0, 9) < 3) begin
            rv_i[p] = 1'b1;
            if (p == 0) a0_i = AW'($urandom); else a1_i = AW'($urandom);
          end
        end else if ($urandom_range(0, 99) < 4) begin
          rv_i[p] = 1'b0;
        end
      end
      ena_i = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 799) == 0) begin
        rst_i = 1'b0; rv_i = 2'b00;
        run(2);
        rst_i = 1'b1;
      end
      step();
      rv_i = rv_i & ~acc;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_read_arbiter.md
# spi_read_arbiter

Two-port round-robin arbiter and sequencer that shares the single `spi_read_byte` SPI master between two requesters: port 0 is CPU instruction fetch and port 1 is CPU data load. It sits between the CPU core and `spi_read_byte` in `tt_um_*`. It accepts byte-read requests on valid/ready handshakes, issues one `start` pulse with a stable address, waits for `done`, and routes `data_out` back to the granted port. A watchdog turns a missing `done` into an error response.

## Interface

Parameters:
- `ADDR_W`, default 16: SPI address width; must match `spi_read_byte.addr`.
- `TIMEOUT_CYCLES`, default 255: cycles allowed from `start` to `done` before an error response; minimum 2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  when low, no new grants are made; an in-flight transaction still completes.
- `req_valid[1:0]`  in  2  per-port request valid; held until accepted.
- `req_addr0`  in  ADDR_W  port 0 address; stable while `req_valid[0]` is high.
- `req_addr1`  in  ADDR_W  port 1 address; stable while `req_valid[1]` is high.
- `req_ready[1:0]`  out  2  per-port accept strobe, one-hot or zero.
- `resp_valid[1:0]`  out  2  per-port one-cycle response strobe.
- `resp_data`  out  8  read byte; valid when any `resp_valid` bit is high.
- `resp_err`  out  1  timeout flag, qualified by `resp_valid`.
- `spi_start`  out  1  to `spi_read_byte.start`; single-cycle pulse.
- `spi_addr`  out  ADDR_W  to `spi_read_byte.addr`; held from accept until return to IDLE.
- `spi_busy`  in  1  from `spi_read_byte.busy`.
- `spi_done`  in  1  from `spi_read_byte.done`; one-cycle pulse.
- `spi_data`  in  8  from `spi_read_byte.data_out`; valid on `spi_done`.

## Operation

- States:
  - IDLE: waits for a request to grant.
  - ISSUE: drives the `spi_start` pulse.
  - WAIT: waits for `spi_done` or timeout.
  - RESP: drives the response strobe.
  - DRAIN: waits for the SPI master to go idle after a timeout.
- IDLE → ISSUE when `ena && |req_valid && !spi_busy`.
  - In that cycle, `req_ready[g]` is driven high combinationally for the winner `g`.
  - `req_addr_g` is latched into `spi_addr` and `g` is latched as the owner.
- Round-robin rule:
  - With one requester, that requester wins.
  - With both requesting, the port that was not granted last wins.
  - After reset, the last-grant pointer is 1, so port 0 wins the first tie.
- ISSUE: `spi_start` = 1 for exactly this cycle; the watchdog counter clears to 0. Next state is WAIT.
- WAIT: the counter increments every cycle.
  - On `spi_done`, `spi_data` is latched into `resp_data` and `resp_err` is set to 0. Next state is RESP.
  - Otherwise, when the counter reaches `TIMEOUT_CYCLES`, `resp_data` is set to 8'hFF and `resp_err` to 1. Next state is RESP.
  - `spi_done` wins if it coincides with the timeout cycle.
- RESP: `resp_valid[owner]` = 1 for one cycle. Next state is IDLE, or DRAIN if `resp_err`.
- DRAIN: holds until `spi_busy` is low, then goes to IDLE.
  - A late `spi_done` seen in DRAIN is discarded and no response is produced.
- `ena` low only blocks the IDLE → ISSUE transition. All other transitions ignore `ena`.
- `resp_data` and `resp_err` hold their values until the next transaction overwrites them.

## Timing

- Reset values:
  - State IDLE, `spi_start` 0, `spi_addr` 0.
  - `req_ready` 0, `resp_valid` 0, `resp_data` 8'h00, `resp_err` 0.
  - Counter 0, last-grant pointer 1.
- Acceptance: `req_valid & req_ready` at cycle T gives `spi_start` high at T+1.
- Response: `spi_done` at cycle D gives `resp_valid` at D+1, which returns to IDLE at D+2.
  - Earliest next accept is D+2.
- Throughput: at most one transaction per (SPI latency + 3) cycles.
- No request is accepted while `spi_busy` is high, including in IDLE.
- A requester may drop `req_valid` before it is accepted without effect; the arbiter does not latch request state.
- Reset mid-transaction: returns to IDLE immediately and no response is emitted. `spi_read_byte` shares `rst_n`.
- Counter width is ceil(log2(`TIMEOUT_CYCLES`+1)) and the counter saturates.

## Structure

- Package `spi_arb_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP, DRAIN);
  - port index constants `PORT_IFETCH` = 0 and `PORT_DLOAD` = 1;
  - the error fill byte constant 8'hFF.
- No sub-module: the round-robin pick is two lines inline.
- `spi_read_byte` is instantiated beside this block in the top level, not inside it.

## Test plan

- Single read: `req_valid` = 2'b01, `req_addr0` = 16'h0042; model returns 8'hA5 with `done` 20 cycles after `start` → `spi_start` one cycle at T+1 with `spi_addr` = 16'h0042, then `resp_valid` = 2'b01 and `resp_data` = 8'hA5 at D+1.
- Tie after reset: both ports valid, addresses 16'h0010 and 16'h0020 → port 0 is granted first, port 1 second, then port 0 again while both stay valid (alternation).
- Busy blocking: hold `spi_busy` = 1 externally with `req_valid` = 2'b10 → `req_ready` stays 0; grant follows in the cycle `spi_busy` falls.
- Timeout: `TIMEOUT_CYCLES` = 8 and the model never pulses `done` while `busy` is held for 30 cycles → `resp_valid` with `resp_err` = 1 and `resp_data` = 8'hFF 9 cycles after `spi_start`; no grant until `busy` falls; a late `done` produces no response.
- `ena` and reset: `ena` = 0 with requests pending → no grant; `ena` dropped during WAIT → the response is still delivered; `rst_n` pulsed during WAIT → all outputs return to reset values and no `resp_valid` is emitted.
